reg_bank: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the multicycle datapath.
- Sits directly downstream of the destination-register select mux, which picks the write target: rd, rt, $sp (29) or $ra (31).
- Provides two combinational read ports feeding the A/B operand registers, and one synchronous write port.
- Holds architectural state: r0 reads as zero, and $sp comes out of reset at a fixed stack-top value.

---
 rtl/reg_bank.sv | 57 +++++
 tb/tb_reg_bank.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// 32 x DATA_W register file: two combinational read ports, one synchronous write port.
// Optional REG_BANK_BYPASS_EN forwards same-cycle write data to a read port that matches write_reg.
module reg_bank #(
    parameter int                DATA_W  = 32,
    parameter int                SP_IDX  = 29,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(227)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int NUM_REGS = 32;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_valid;

    // r0 is never stored to, so its flop stays at its reset value of zero.
    assign wr_valid = reg_write && (write_reg != 5'd0);

    // NOTE: every entry sits in the async reset so no read can ever return X;
    // this file is built from flops, not a RAM macro, so a memory reset is legal.
    // Sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wr_valid) begin
            regs[write_reg] <= write_data;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    logic fwd_en;
    assign fwd_en = wr_valid && !reset;
`endif

    // NOTE: both outputs get a default before any override, so no latch is inferred.
    always_comb begin
        read_data1 = regs[read_reg1];
        read_data2 = regs[read_reg2];
`ifdef REG_BANK_BYPASS_EN
        if (fwd_en && (read_reg1 == write_reg)) read_data1 = write_data;
        if (fwd_en && (read_reg2 == write_reg)) read_data2 = write_data;
`endif
        if (read_reg1 == 5'd0) read_data1 = '0;
        if (read_reg2 == 5'd0) read_data2 = '0;
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank; expected values are hand-computed constants.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int n_tests = 0;
    int n_fail  = 0;

    reg_bank dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    // Gated clock: stops low when clk_run is cleared right after a falling edge.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [31:0] data, input logic we);
        @(negedge clk);
        reg_write  = we;
        write_reg  = idx;
        write_data = data;
        @(negedge clk);
        reg_write  = 1'b0;
    endtask

    task automatic read_pair(input logic [4:0] a, input logic [4:0] b);
        read_reg1 = a;
        read_reg2 = b;
        #1;
    endtask

    task automatic check_reset_contents(input string tag);
        for (int i = 0; i < 32; i++) begin
            read_pair(5'(i), 5'(31 - i));
            check($sformatf("%s p1 r%0d", tag, i), read_data1, (i == 29) ? 32'd227 : 32'd0);
            check($sformatf("%s p2 r%0d", tag, 31 - i), read_data2, ((31 - i) == 29) ? 32'd227 : 32'd0);
        end
    endtask

    initial begin
        // Initial async reset with the clock stopped.
        #3 reset = 1'b1;
        #4 reset = 1'b0;
        #1;
        check_reset_contents("por");

        // Dirty a couple of registers, including $sp as an ordinary register.
        clk_run = 1'b1;
        do_write(5'd3, 32'h0000_0055, 1'b1);
        do_write(5'd29, 32'h0000_1000, 1'b1);
        read_pair(5'd3, 5'd29);
        check("r3 written", read_data1, 32'h0000_0055);
        check("sp written", read_data2, 32'h0000_1000);

        // Stop the clock, then pulse reset mid-cycle: outputs must change with no edge.
        @(negedge clk);
        clk_run = 1'b0;
        #12;
        reset = 1'b1;
        #1;
        check("async r3 cleared", read_data1, 32'd0);
        check("async sp restored", read_data2, 32'd227);
        #3 reset = 1'b0;
        #1;
        check_reset_contents("mid");

        // Restart clock; write r5 and read it on both ports.
        clk_run = 1'b1;
        do_write(5'd5, 32'hDEAD_BEEF, 1'b1);
        read_pair(5'd5, 5'd5);
        check("r5 port1", read_data1, 32'hDEAD_BEEF);
        check("r5 port2", read_data2, 32'hDEAD_BEEF);

        // r0 immunity.
        do_write(5'd0, 32'hFFFF_FFFF, 1'b1);
        read_pair(5'd0, 5'd0);
        check("r0 port1", read_data1, 32'd0);
        check("r0 port2", read_data2, 32'd0);

        // Write-enable gating, then a real $ra write.
        do_write(5'd31, 32'h0000_1234, 1'b0);
        read_pair(5'd31, 5'd5);
        check("r31 gated", read_data1, 32'd0);
        check("r5 untouched", read_data2, 32'hDEAD_BEEF);
        do_write(5'd31, 32'h0040_0010, 1'b1);
        read_pair(5'd31, 5'd31);
        check("ra written", read_data1, 32'h0040_0010);

        // Same-cycle read of r8 while writing it.
        do_write(5'd8, 32'd7, 1'b1);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd8;
        write_data = 32'd9;
        read_pair(5'd8, 5'd0);
`ifdef REG_BANK_BYPASS_EN
        check("r8 same cycle", read_data1, 32'd9);
`else
        check("r8 same cycle", read_data1, 32'd7);
`endif
        check("r0 during write", read_data2, 32'd0);
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        check("r8 after edge", read_data1, 32'd9);

        // No forwarding when reg_write is low, and never onto r0.
        write_reg  = 5'd8;
        write_data = 32'h77;
        #1;
        check("r8 no fwd when we=0", read_data1, 32'd9);
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'hCAFE_F00D;
        read_pair(5'd0, 5'd8);
        check("r0 never fwd", read_data1, 32'd0);
        check("r8 unaffected by r0 wr", read_data2, 32'd9);
        @(negedge clk);
        reg_write = 1'b0;

        // Reset concurrent with a pending write to r10: the write is lost.
        do_write(5'd10, 32'hA5A5_A5A5, 1'b1);
        read_pair(5'd10, 5'd29);
        check("r10 preset", read_data1, 32'hA5A5_A5A5);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd10;
        write_data = 32'd1;
        #4 reset = 1'b1;
        @(negedge clk);
        reg_write = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("r10 after reset", read_data1, 32'd0);
        check("sp after reset", read_data2, 32'd227);
        read_pair(5'd8, 5'd31);
        check("r8 after reset", read_data1, 32'd0);
        check("r31 after reset", read_data2, 32'd0);

        clk_run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
